write_fifo: RTL and testbench

- Synchronous FIFO that sits directly downstream of the multi-writer arbiter.
- Captures each arbiter write (we + data) into a circular buffer and presents a record count, full/empty status and sticky error flags.
- A consumer (UART/logger stage) drains it with a single-cycle read strobe and registered read data.
- Lets the formal and sim environments check record counts against accepted writes.

---
 rtl/write_fifo.sv | 85 ++++++++
 tb/tb_write_fifo.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/write_fifo.sv
// Synchronous circular-buffer FIFO behind the multi-writer arbiter.
// Keeps a record count, registered full/empty, and sticky overflow/underflow flags.
module write_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_we,
   input  logic [DATA_W-1:0]        i_wdata,
   input  logic                     i_re,
   output logic [DATA_W-1:0]        o_rdata,
   output logic                     o_rvalid,
   output logic [$clog2(DEPTH):0]   o_records,
   output logic                     o_full,
   output logic                     o_empty,
   output logic                     o_overflow,
   output logic                     o_underflow
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr_r;
   logic [AW-1:0]     rptr_r;
   logic              rd_ok_s;
   logic              wr_ok_s;
   logic [CNT_W-1:0]  rec_next_s;

   // Accept decisions; a full FIFO still takes a write when a read frees a slot.
   always_comb begin
      rd_ok_s = i_re && !o_empty;
      wr_ok_s = i_we && (!o_full || rd_ok_s);
   end

   // Next record count from the accepted write/read pair.
   always_comb begin
      rec_next_s = o_records;
      case ({wr_ok_s, rd_ok_s})
         2'b10:   rec_next_s = o_records + CNT_W'(1);
         2'b01:   rec_next_s = o_records - CNT_W'(1);
         default: rec_next_s = o_records;
      endcase
   end

   // Storage array; contents are not cleared by reset.
   always_ff @(posedge i_clk) begin
      if (wr_ok_s && !i_reset) begin
         mem[wptr_r] <= i_wdata;
      end
   end

   // Pointers, registered read port, status and sticky error flags.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wptr_r      <= {AW{1'b0}};
         rptr_r      <= {AW{1'b0}};
         o_rdata     <= {DATA_W{1'b0}};
         o_rvalid    <= 1'b0;
         o_records   <= {CNT_W{1'b0}};
         o_full      <= 1'b0;
         o_empty     <= 1'b1;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         if (wr_ok_s) begin
            wptr_r <= wptr_r + AW'(1);
         end
         if (rd_ok_s) begin
            o_rdata  <= mem[rptr_r];
            rptr_r   <= rptr_r + AW'(1);
            o_rvalid <= 1'b1;
         end else begin
            o_rvalid <= 1'b0;
         end
         o_records   <= rec_next_s;
         o_full      <= (rec_next_s == CNT_W'(DEPTH));
         o_empty     <= (rec_next_s == {CNT_W{1'b0}});
         o_overflow  <= o_overflow  | (i_we && !wr_ok_s);
         o_underflow <= o_underflow | (i_re && !rd_ok_s);
      end
   end

endmodule

// File: tb/tb_write_fifo.sv
// Scoreboard bench for write_fifo: a queue-based reference model predicts every
// read word and status value, and a negedge monitor compares the DUT against it.
module tb_write_fifo;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              we  = 1'b0;
   logic [DATA_W-1:0] wd  = '0;
   logic              re  = 1'b0;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic [CNT_W-1:0]  records;
   logic              full, empty, overflow, underflow;

   write_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_reset(rst), .i_we(we), .i_wdata(wd), .i_re(re),
      .o_rdata(rdata), .o_rvalid(rvalid), .o_records(records),
      .o_full(full), .o_empty(empty), .o_overflow(overflow), .o_underflow(underflow)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [DATA_W-1:0] mq[$];
   logic [DATA_W-1:0] exp_q[$];
   bit                checking = 0;
   bit                m_ov = 0, m_un = 0, m_rv = 0;
   logic [DATA_W-1:0] m_hold = '0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: updates on the same edge as the DUT from stable inputs
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         exp_q.delete();
         m_ov = 0; m_un = 0; m_rv = 0; m_hold = '0;
         checking = 1;
      end else begin
         bit rd_acc, wr_acc;
         rd_acc = re && (mq.size() > 0);
         wr_acc = we && ((mq.size() < DEPTH) || rd_acc);
         if (re && !rd_acc) m_un = 1;
         if (we && !wr_acc) m_ov = 1;
         m_rv = rd_acc;
         if (rd_acc) begin
            m_hold = mq.pop_front();
            exp_q.push_back(m_hold);
         end
         if (wr_acc) mq.push_back(wd);
      end
   end

   // monitor: pops the scoreboard when the DUT presents read data
   always @(negedge clk) begin
      if (checking) begin
         check("rvalid", int'(rvalid), int'(m_rv));
         if (rvalid) begin
            if (exp_q.size() == 0) begin
               check("rdata_unexpected", 1, 0);
            end else begin
               logic [DATA_W-1:0] e;
               e = exp_q.pop_front();
               check("rdata", int'(rdata), int'(e));
            end
         end else begin
            check("rdata_hold", int'(rdata), int'(m_hold));
         end
         check("records", int'(records), mq.size());
         check("full", int'(full), int'(mq.size() == DEPTH));
         check("empty", int'(empty), int'(mq.size() == 0));
         check("overflow", int'(overflow), int'(m_ov));
         check("underflow", int'(underflow), int'(m_un));
      end
   end

   task automatic step(input bit r, input bit w, input logic [DATA_W-1:0] d, input bit rd);
      rst = r; we = w; wd = d; re = rd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1;
      step(1, 0, 8'h00, 0);
      step(1, 0, 8'h00, 0);
      // fill, then simultaneous write+read while full, then drain and underflow
      for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h11 + i), 0);
      step(0, 1, 8'hAA, 1);
      for (int i = 0; i < 9; i++) step(0, 0, 8'h00, 1);
      // fill, overflow with 0x99, drain, read on empty
      step(1, 0, 8'h00, 0);
      for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h11 + i), 0);
      step(0, 1, 8'h99, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);
      // alternating write/read across pointer wrap
      step(1, 0, 8'h00, 0);
      for (int i = 0; i < 12; i++) begin
         step(0, 1, 8'(8'h40 + i), 0);
         step(0, 0, 8'h00, 1);
      end
      // write and read while empty: read rejected, write accepted
      step(0, 1, 8'h5A, 1);
      step(0, 0, 8'h00, 1);
      // partial fill, reset with both strobes, then write/read after reset
      for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h60 + i), 0);
      step(1, 1, 8'hEE, 1);
      step(0, 1, 8'hC3, 0);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);
      // randomized phases with varying write/read bias
      for (int ph = 0; ph < 8; ph++) begin
         int pw, pr;
         pw = int'($urandom_range(10, 90));
         pr = int'($urandom_range(10, 90));
         for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < pw),
                 8'($urandom), ($urandom_range(0, 99) < pr));
         end
      end
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
